// File: rtl/mult_arbiter_if.sv
// Request/result bundle between the requesters, the arbiter and the shared multiplier.
// The slave modport is the arbiter's view; master is the requester/multiplier side.
interface mult_arbiter_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 3,
  parameter int unsigned LAT  = 2
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*N-1:0]          req_a;
  logic [NREQ*N-1:0]          req_b;
  logic [NREQ-1:0]            req_ready;
  logic [N-1:0]               mult_a;
  logic [N-1:0]               mult_b;
  logic [2*N-1:0]             mult_result;
  logic [NREQ-1:0]            res_valid;
  logic [2*N-1:0]             res_data;
  logic [$clog2(LAT+1)-1:0]   inflight;

  modport slave (
    input  req_valid, req_a, req_b, mult_result,
    output req_ready, mult_a, mult_b, res_valid, res_data, inflight
  );

  modport master (
    output req_valid, req_a, req_b, mult_result,
    input  req_ready, mult_a, mult_b, res_valid, res_data, inflight
  );
endinterface

// File: rtl/mult_arbiter.sv
// Shares one pipelined signed multiplier between NREQ requesters and routes products back by tag.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREQ = 3,
  parameter int unsigned LAT  = 2
) (
  input logic          clk,
  input logic          rst,
  mult_arbiter_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LAT + 1);

  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          accept;
  logic          ret;
  logic [LAT-1:0] tag_vld;
  logic [IW-1:0]  tag_idx [LAT];
  logic [CW-1:0]  cnt;

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_any && !rst && bus.req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  // Scan starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!gnt_any && !rst && bus.req_valid[IW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

  // Grant only goes to a valid requester, so any grant is an accepted transfer.
  assign accept = gnt_any;

  always_comb begin
    bus.req_ready = '0;
    bus.mult_a    = '0;
    bus.mult_b    = '0;
    if (gnt_any) begin
      bus.req_ready[gnt_idx] = 1'b1;
      bus.mult_a = bus.req_a[gnt_idx*N +: N];
      bus.mult_b = bus.req_b[gnt_idx*N +: N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld[0] <= accept;
      tag_idx[0] <= gnt_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  assign ret = tag_vld[LAT-1];

  always_comb begin
    bus.res_valid = '0;
    if (ret) begin
      bus.res_valid[tag_idx[LAT-1]] = 1'b1;
    end
  end

  assign bus.res_data = bus.mult_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({accept, ret})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.inflight = cnt;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier and a queue-based result model.
module tb_mult_arbiter;
  localparam int unsigned N    = 8;
  localparam int unsigned NREQ = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned PW   = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mult_arbiter_if #(.N(N), .NREQ(NREQ), .LAT(LAT)) bus ();

  mult_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: registered operands, registered product.
  logic signed [N-1:0]  ma_r, mb_r;
  logic signed [PW-1:0] mp;
  always @(posedge clk) begin
    ma_r <= bus.mult_a;
    mb_r <= bus.mult_b;
    mp   <= PW'(ma_r) * PW'(mb_r);
  end
  assign bus.mult_result = mp;

  // Requester stimulus state
  logic [NREQ-1:0] va;
  logic [N-1:0]    aa [NREQ];
  logic [N-1:0]    ba [NREQ];

  task automatic pack;
    bus.req_valid = va;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*N +: N] = aa[i];
      bus.req_b[i*N +: N] = ba[i];
    end
  endtask

  // Reference model: expected grant from the arbitration rule, results as a due-cycle queue.
  typedef struct { int due; int idx; int prod; } ent_t;
  ent_t q[$];
  int   ptr = 0;
  int   cyc = 0;

  function automatic int exp_grant(logic [NREQ-1:0] v);
    if (rst) return -1;
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int o = 0; o < NREQ; o++) if (v[o]) return o;
`else
    for (int o = 0; o < NREQ; o++) if (v[(ptr + o) % NREQ]) return (ptr + o) % NREQ;
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    logic signed [N-1:0] oa, ob;
    if (rst) begin
      q.delete();
      ptr = 0;
    end else begin
      cyc++;
      g = exp_grant(bus.req_valid);
      if (g >= 0) begin
        oa = bus.req_a[g*N +: N];
        ob = bus.req_b[g*N +: N];
        q.push_back('{due: cyc + LAT - 1, idx: g, prod: int'(oa) * int'(ob)});
        ptr = (g + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] erv;
    logic [PW-1:0]   edata;
    int              einf;
    erv   = '0;
    edata = '0;
    einf  = q.size();
    if (q.size() > 0 && q[0].due == cyc && !rst) begin
      erv[q[0].idx] = 1'b1;
      edata = PW'(q[0].prod);
    end
    checks++;
    if (bus.res_valid !== erv) begin
      failures++;
      $display("FAIL res_valid_route: got %b expected %b at %0t", bus.res_valid, erv, $time);
    end
    if (erv != '0) begin
      checks++;
      if (bus.res_data !== edata) begin
        failures++;
        $display("FAIL res_data_model: got %h expected %h at %0t", bus.res_data, edata, $time);
      end
      void'(q.pop_front());
    end
    checks++;
    if (int'(bus.inflight) != einf) begin
      failures++;
      $display("FAIL inflight_model: got %0d expected %0d at %0t", bus.inflight, einf, $time);
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    va = '1;
    for (int i = 0; i < NREQ; i++) begin aa[i] = 8'h11; ba[i] = 8'h22; end
    pack;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready: got %b expected 000", bus.req_ready); end
    checks++;
    if (bus.res_valid !== 3'b000) begin failures++; $display("FAIL reset_res_valid: got %b expected 000", bus.res_valid); end
    checks++;
    if (bus.inflight !== 2'd0) begin failures++; $display("FAIL reset_inflight: got %0d expected 0", bus.inflight); end
    checks++;
    if (bus.mult_a !== 8'h00 || bus.mult_b !== 8'h00) begin
      failures++; $display("FAIL reset_operands: got %h/%h expected 00/00", bus.mult_a, bus.mult_b);
    end
    va = '0; pack;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single;
    va = 3'b001; aa[0] = 8'h03; ba[0] = 8'hFE; pack;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL single_ready: got %b expected 001", bus.req_ready); end
    checks++;
    if (bus.mult_a !== 8'h03 || bus.mult_b !== 8'hFE) begin
      failures++; $display("FAIL single_operands: got %h/%h expected 03/fe", bus.mult_a, bus.mult_b);
    end
    @(posedge clk); #1 va = '0; pack;
    for (int c = 0; c < LAT - 1; c++) begin
      @(negedge clk);
      checks++;
      if (bus.inflight !== 2'd1 || bus.res_valid !== 3'b000) begin
        failures++; $display("FAIL single_pending: got inflight=%0d rv=%b expected 1/000", bus.inflight, bus.res_valid);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 3'b001 || bus.res_data !== 16'hFFFA) begin
      failures++; $display("FAIL single_result: got %b/%h expected 001/fffa", bus.res_valid, bus.res_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.inflight !== 2'd0) begin failures++; $display("FAIL single_drain: got %0d expected 0", bus.inflight); end
    @(posedge clk); #1;
  endtask

  task automatic test_extreme;
    int          rq [3]  = '{1, 1, 2};
    logic [7:0]  ta [3]  = '{8'h80, 8'h7F, 8'hFF};
    logic [7:0]  tb_ [3] = '{8'h80, 8'h80, 8'hFF};
    logic [15:0] tp [3]  = '{16'h4000, 16'hC080, 16'h0001};
    logic [2:0]  er;
    for (int t = 0; t < 3; t++) begin
      va = '0; va[rq[t]] = 1'b1; aa[rq[t]] = ta[t]; ba[rq[t]] = tb_[t]; pack;
      er = '0; er[rq[t]] = 1'b1;
      @(posedge clk); #1 va = '0; pack;
      repeat (LAT - 1) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (bus.res_valid !== er || bus.res_data !== tp[t]) begin
        failures++; $display("FAIL extreme_%0d: got %b/%h expected %b/%h", t, bus.res_valid, bus.res_data, er, tp[t]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin;
    int exp_seq [8];
    logic [2:0] er;
`ifdef MULT_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0, 0, 1, 1};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2, 1, 2};
`endif
    do_reset;
    va = 3'b111;
    for (int i = 0; i < NREQ; i++) begin aa[i] = 8'($urandom); ba[i] = 8'($urandom); end
    pack;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin va[0] = 1'b0; pack; end
      er = 3'b001 << exp_seq[c];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== er) begin failures++; $display("FAIL rr_grant_%0d: got %b expected %b", c, bus.req_ready, er); end
      checks++;
      if (bus.mult_a !== aa[exp_seq[c]] || bus.mult_b !== ba[exp_seq[c]]) begin
        failures++; $display("FAIL rr_operands_%0d: got %h/%h expected %h/%h", c, bus.mult_a, bus.mult_b, aa[exp_seq[c]], ba[exp_seq[c]]);
      end
      @(posedge clk); #1;
      aa[exp_seq[c]] = 8'($urandom); ba[exp_seq[c]] = 8'($urandom); pack;
    end
    va = '0; pack;
  endtask

  task automatic test_pointer_skip;
    int exp_seq [4];
    logic [2:0] add [4] = '{3'b001, 3'b101, 3'b000, 3'b111};
    logic [2:0] er;
`ifdef MULT_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 2, 0};
`else
    exp_seq = '{0, 2, 0, 1};
`endif
    do_reset;
    va = '0;
    for (int c = 0; c < 4; c++) begin
      va = va | add[c];
      for (int i = 0; i < NREQ; i++) begin aa[i] = 8'($urandom); ba[i] = 8'($urandom); end
      pack;
      er = 3'b001 << exp_seq[c];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== er) begin failures++; $display("FAIL skip_grant_%0d: got %b expected %b", c, bus.req_ready, er); end
      @(posedge clk); #1;
      va[exp_seq[c]] = 1'b0; pack;
    end
    va = '0; pack;
  endtask

  task automatic test_reset_midflight;
    va = 3'b001; aa[0] = 8'h05; ba[0] = 8'h06; pack;
    @(posedge clk); #1;
    va = 3'b010; aa[1] = 8'h07; ba[1] = 8'h09; pack;
    @(posedge clk); #1;
    va = 3'b111; pack;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 3'b000 || bus.res_valid !== 3'b000 || bus.inflight !== 2'd0) begin
      failures++; $display("FAIL midflight_reset: got rdy=%b rv=%b inf=%0d expected 000/000/0", bus.req_ready, bus.res_valid, bus.inflight);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    va = 3'b001; aa[0] = 8'h03; ba[0] = 8'h04; pack;
    @(posedge clk); #1 va = '0; pack;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 3'b001 || bus.res_data !== 16'h000C) begin
      failures++; $display("FAIL midflight_fresh: got %b/%h expected 001/000c", bus.res_valid, bus.res_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int g;
    logic [2:0] er;
    va = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!va[i] && $urandom_range(0, 2) != 0) begin
          va[i] = 1'b1; aa[i] = 8'($urandom); ba[i] = 8'($urandom);
        end
      end
      pack;
      @(negedge clk);
      g  = exp_grant(va);
      er = (g >= 0) ? (3'b001 << g) : 3'b000;
      checks++;
      if (bus.req_ready !== er) begin failures++; $display("FAIL rand_grant_%0d: got %b expected %b", c, bus.req_ready, er); end
      if (g >= 0) begin
        checks++;
        if (bus.mult_a !== aa[g] || bus.mult_b !== ba[g]) begin
          failures++; $display("FAIL rand_operands_%0d: got %h/%h expected %h/%h", c, bus.mult_a, bus.mult_b, aa[g], ba[g]);
        end
      end
      @(posedge clk); #1;
      if (g >= 0) va[g] = 1'b0;
    end
    va = '0; pack;
    repeat (LAT + 2) begin @(posedge clk); #1; end
    checks++;
    if (bus.inflight !== 2'd0) begin failures++; $display("FAIL rand_drain: got %0d expected 0", bus.inflight); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    va = '0;
    for (int i = 0; i < NREQ; i++) begin aa[i] = '0; ba[i] = '0; end
    pack;
    test_reset;
    test_single;
    test_extreme;
    test_round_robin;
    test_pointer_skip;
    test_reset_midflight;
    test_random;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one pipelined signed multiplier (registered operands, registered product, LAT=2 clock edges) between NREQ requesters.
- Each requester presents operands with a valid/ready handshake. The arbiter grants at most one request per cycle and drives the multiplier's operand inputs.
- A tag is carried alongside every in-flight operation so each product is routed back to the requester that issued it.
- Sits between the pico-MIPS execute stage and its auxiliary units and the single shared multiplier instance.

Parameters:
- N, 8, operand width in bits; product is 2*N bits.
- NREQ, 3, number of requesters (2..8).
- LAT, 2, multiplier latency in clock edges from operand capture to product valid.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request; must stay high, with operands stable, until accepted.
- req_a  input  NREQ*N  packed operand A; slice i belongs to requester i; two's complement.
- req_b  input  NREQ*N  packed operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; transfer for requester i occurs when req_valid[i] and req_ready[i] are high at a rising edge.
- mult_a  output  N  operand A to multiplier, slice of the granted requester.
- mult_b  output  N  operand B to multiplier, slice of the granted requester.
- mult_result  input  2*N  registered signed product from multiplier.
- res_valid  output  NREQ  one-hot, single-cycle pulse marking the owner of res_data.
- res_data  output  2*N  product, equal to mult_result, shared by all requesters.
- inflight  output  $clog2(LAT+1)  number of accepted operations not yet returned.

Behaviour:
- Reset: req_ready=0, res_valid=0, inflight=0, tag pipeline cleared, round-robin pointer=0.
- mult_a/mult_b are combinational; they are driven to 0 when no grant is active.
- Arbitration is combinational in the same cycle. Among asserted req_valid bits, the first index at or after rr_ptr (wrapping) is granted.
  - req_ready is asserted only for that index.
  - req_ready is never asserted for a requester whose req_valid is low.
- On an accepted transfer, rr_ptr <= granted index + 1, modulo NREQ. With no transfer, rr_ptr holds.
- Throughput: one issue per cycle, no bubbles. The multiplier never stalls, so there is no backpressure on results.
- Tag pipeline: LAT-stage shift register of {valid, index}. Stage 0 loads the accepted grant, or valid=0 if none; it shifts every cycle.
  - When the final stage is valid, res_valid[index]=1 for exactly that cycle and res_data=mult_result.
  - An operation accepted at edge E produces its res_valid pulse in the cycle after edge E+LAT-1, i.e. visible LAT cycles after the request cycle.
- res_data equals mult_result at all times. It is meaningful only while some res_valid bit is high.
- inflight: +1 on accept, -1 on result return. Accept and return in the same cycle leave it unchanged. It never exceeds LAT.
- Width rules: product is full-precision signed 2*N. The block performs no truncation or saturation. -2^(N-1) * -2^(N-1) = 2^(2N-2) fits.
- Reset mid-operation: in-flight tags are discarded and no res_valid pulses appear for them. Requesters must reissue.
- A requester may have several operations in flight; results return in issue order.

Optional Feature:
- Macro: MULT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest asserted index is always granted, and rr_ptr logic is removed.
- Undefined (default): round-robin as specified above.
- Tag pipeline, latency and result routing are identical in both modes.

Test Plan:
- Single issue (N=8, NREQ=3): req0 a=8'h03, b=8'hFE accepted at cycle 1 -> res_valid=3'b001, res_data=16'hFFFA in cycle 3; inflight goes 1 then 0.
- Extreme operands: req1 a=8'h80, b=8'h80 -> res_valid=3'b010, res_data=16'h4000. Also a=8'h7F, b=8'h80 -> 16'hC080.
- Round-robin fairness: all three req_valid held high for 6 cycles -> grants 0,1,2,0,1,2; results return in that order, one per cycle, each LAT cycles after its grant.
- Pointer skip: rr_ptr=1, only req0 and req2 asserted -> req2 granted first, then req0; rr_ptr ends at 1.
- Reset mid-flight: assert rst one cycle after two accepts -> outputs 0 immediately, no res_valid for either op; a fresh req0 3*4 returns 16'h000C.
- MULT_ARB_FIXED_PRIO_EN defined, all requests high -> req0 granted every cycle; req1 and req2 are granted only after req_valid[0] drops.
